// File: rtl/regif_rd_resp_if.sv
// regif_rd_resp_if: REGIF master-read bus between a host-access read
// initiator (master) and a register read responder (slave).
interface regif_rd_resp_if;
  logic        IP2Bus_MstRd_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic        Bus2IP_Mst_CmdAck;
  logic        Bus2IP_Mst_Cmplt;
  logic        Bus2IP_Mst_Error;
  logic [31:0] Bus2IP_MstRd_d;
  logic        Bus2IP_MstRd_src_rdy_n;

  modport master (
    output IP2Bus_MstRd_Req, IP2Bus_Mst_Addr,
    input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
    input  Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n
  );

  modport slave (
    input  IP2Bus_MstRd_Req, IP2Bus_Mst_Addr,
    output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
    output Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n
  );
endinterface

// File: rtl/regif_rd_resp.sv
// regif_rd_resp: REGIF read responder. Accepts one master read at a time,
// decodes it against a local word window, fetches the word from the register
// bank over a strobe/valid port and returns a single beat with status.
// Optional build macro REGIF_RD_RESP_STATS_EN adds saturating good/error
// read counters (rd_ok_cnt, rd_err_cnt).
module regif_rd_resp #(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_1000,
  parameter int          ADDR_WORDS     = 256,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                          clk,
  input  logic                          rst,
  regif_rd_resp_if.slave                bus,
  output logic                          reg_rd_en,
  output logic [$clog2(ADDR_WORDS)-1:0] reg_rd_addr,
  input  logic [31:0]                   reg_rd_data,
  input  logic                          reg_rd_valid,
  output logic                          busy
`ifdef REGIF_RD_RESP_STATS_EN
  ,
  output logic [31:0]                   rd_ok_cnt,
  output logic [31:0]                   rd_err_cnt
`endif
);
  localparam int            AW         = $clog2(ADDR_WORDS);
  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_WAIT, S_RESP, S_GAP} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          in_range_q;
  logic          ack_q;
  logic          en_q;
  logic          cmplt_q;
  logic          error_q;
  logic          src_rdy_n_q;
  logic          busy_q;
  logic [31:0]   data_q;
  logic [AW-1:0] addr_q;

  // Window decode straight off the request address; offset wraps modulo 2^32
  // so addresses below the base land far out of range.
  logic [31:0]   off_w;
  logic          in_range_w;
  logic [AW-1:0] idx_w;
  logic          unused_off;

  assign off_w      = bus.IP2Bus_Mst_Addr - ADDR_BASE;
  assign in_range_w = (bus.IP2Bus_Mst_Addr[1:0] == 2'b00) && (off_w[31:AW+2] == '0);
  assign idx_w      = off_w[AW+1:2];
  assign unused_off = ^off_w[1:0];

  // Transaction FSM; every bus-facing output is a register set on entry to the
  // state it belongs to, and strobes default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      in_range_q  <= 1'b0;
      ack_q       <= 1'b0;
      en_q        <= 1'b0;
      cmplt_q     <= 1'b0;
      error_q     <= 1'b0;
      src_rdy_n_q <= 1'b1;
      busy_q      <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
    end else begin
      ack_q       <= 1'b0;
      en_q        <= 1'b0;
      cmplt_q     <= 1'b0;
      error_q     <= 1'b0;
      src_rdy_n_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (bus.IP2Bus_MstRd_Req) begin
            state_q    <= S_ACK;
            ack_q      <= 1'b1;
            busy_q     <= 1'b1;
            in_range_q <= in_range_w;
            if (in_range_w) begin
              en_q   <= 1'b1;
              addr_q <= idx_w;
            end
          end
        end
        S_ACK: begin
          if (in_range_q) begin
            timer_q <= '0;
            state_q <= S_WAIT;
          end else begin
            state_q     <= S_RESP;
            cmplt_q     <= 1'b1;
            error_q     <= 1'b1;
            src_rdy_n_q <= 1'b0;
            data_q      <= ERR_DATA;
          end
        end
        S_WAIT: begin
          // Data arriving on the last allowed cycle still counts as success.
          if (reg_rd_valid) begin
            state_q     <= S_RESP;
            cmplt_q     <= 1'b1;
            src_rdy_n_q <= 1'b0;
            data_q      <= reg_rd_data;
          end else if (timer_q == TIMER_LAST) begin
            state_q     <= S_RESP;
            cmplt_q     <= 1'b1;
            error_q     <= 1'b1;
            src_rdy_n_q <= 1'b0;
            data_q      <= ERR_DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q <= S_GAP;
          busy_q  <= 1'b0;
        end
        S_GAP: begin
          // Dead cycle so a master dropping Req after CmdAck is not re-accepted.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Bus2IP_Mst_CmdAck      = ack_q;
  assign bus.Bus2IP_Mst_Cmplt       = cmplt_q;
  assign bus.Bus2IP_Mst_Error       = error_q;
  assign bus.Bus2IP_MstRd_d         = data_q;
  assign bus.Bus2IP_MstRd_src_rdy_n = src_rdy_n_q;
  assign reg_rd_en                  = en_q;
  assign reg_rd_addr                = addr_q;
  assign busy                       = busy_q;

`ifdef REGIF_RD_RESP_STATS_EN
  logic [31:0] ok_cnt_q;
  logic [31:0] err_cnt_q;

  // Saturating tallies of completed beats, bumped from the registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (cmplt_q) begin
      if (error_q) begin
        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
      end else begin
        if (ok_cnt_q != 32'hFFFF_FFFF) ok_cnt_q <= ok_cnt_q + 32'd1;
      end
    end
  end

  assign rd_ok_cnt  = ok_cnt_q;
  assign rd_err_cnt = err_cnt_q;
`endif
endmodule

// File: doc/regif_rd_resp.md
Name: regif_rd_resp

Overview:
- Register-interface read responder (slave side).
- Accepts master read requests on the REGIF bus (IP2Bus_MstRd_Req, IP2Bus_Mst_Addr) and decodes the address against a local register window.
- Fetches the word from the local register bank through a simple request/valid port.
- Returns one data beat plus completion/error status on the Bus2IP_* signals consumed by the host-access read initiator.

Parameters:
ADDR_BASE, 32'h0000_1000, byte address of first word in window
ADDR_WORDS, 256, window size in 32-bit words; power of 2
TIMEOUT_CYCLES, 64, max cycles to wait for reg_rd_valid before erroring
ERR_DATA, 32'hDEAD_BEEF, data returned on any error beat

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
IP2Bus_MstRd_Req  in  1  master read request (level)
IP2Bus_Mst_Addr  in  32  byte address, sampled with Req
Bus2IP_Mst_CmdAck  out  1  one-cycle request accept pulse
Bus2IP_Mst_Cmplt  out  1  one-cycle completion pulse
Bus2IP_Mst_Error  out  1  error flag, valid with Cmplt
Bus2IP_MstRd_d  out  32  read data, valid while src_rdy_n low
Bus2IP_MstRd_src_rdy_n  out  1  active-low data-valid strobe
reg_rd_en  out  1  one-cycle read strobe to register bank
reg_rd_addr  out  log2(ADDR_WORDS)  word index into bank
reg_rd_data  in  32  bank read data
reg_rd_valid  in  1  bank data-valid pulse (latency >=1)
busy  out  1  high from accept to return to IDLE

Behaviour:
- Reset values (async on rst rise, independent of clk):
  - CmdAck = 0, Cmplt = 0, Error = 0, reg_rd_en = 0, busy = 0
  - src_rdy_n = 1, MstRd_d = 0, reg_rd_addr = 0
  - FSM = IDLE, timeout counter = 0
- Reset during any state aborts the transaction silently; no Cmplt is issued.
- FSM states: IDLE, ACK, WAIT, RESP, GAP.
- IDLE:
  - On Req = 1 at edge T: latch addr, go to ACK.
  - Address decode uses off = addr - ADDR_BASE (32-bit unsigned wrap).
  - In-range when addr[1:0] == 0 and off[31:2] < ADDR_WORDS; otherwise range error.
- ACK (cycle T+1):
  - CmdAck = 1 for exactly one cycle; busy = 1.
  - If in-range: reg_rd_en = 1, reg_rd_addr = off[log2+1:2], clear timer, go to WAIT.
  - Else: go to RESP with err = 1.
- WAIT:
  - Timer increments each cycle.
  - reg_rd_valid = 1: capture reg_rd_data, err = 0, go to RESP.
  - Timer reaches TIMEOUT_CYCLES-1 without valid: err = 1, go to RESP.
  - If valid and timeout coincide, valid wins.
  - A late reg_rd_valid after timeout is ignored.
- RESP (one cycle), all three signals in the same cycle:
  - src_rdy_n = 0
  - Cmplt = 1, Error = err
  - MstRd_d = captured data, or ERR_DATA if err
- Next cycle: src_rdy_n = 1, Cmplt = 0, Error = 0; MstRd_d holds its value. Go to GAP.
- GAP: one dead cycle, busy = 0, go to IDLE. This guarantees >=3 cycles from CmdAck to re-sampling Req, so a master that drops Req one cycle after CmdAck is never double-accepted.
- Req deasserting after ACK does not cancel the read; it always completes.
- Latency:
  - In-range read: Cmplt at T+2+L, where L = bank latency in cycles from reg_rd_en to reg_rd_valid.
  - Range error: Cmplt at T+2.
- Back-to-back requests: minimum accept-to-accept spacing of 4 cycles (error case).

Optional Feature:
- Macro: REGIF_RD_RESP_STATS_EN.
- Defined:
  - Extra output ports rd_ok_cnt[31:0] and rd_err_cnt[31:0], reset to 0.
  - Each increments by one in the RESP cycle according to Error.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-WAIT -> outputs immediately at reset values; after release, next Req is served normally with no stale Cmplt.
- In-range read: Req, addr 32'h0000_1010, bank returns 32'hCAFE_0004 with L=2 -> CmdAck at T+1; reg_rd_addr=4; at T+4 src_rdy_n=0, Cmplt=1, Error=0, d=32'hCAFE_0004.
- Out of range / misaligned: addr 32'h0000_0FFC, then 32'h0000_1402, then 32'h0000_1001 -> each returns CmdAck, then Cmplt at T+2 with Error=1, d=32'hDEAD_BEEF; reg_rd_en never pulses.
- Timeout: in-range addr, bank never asserts valid -> Cmplt + Error=1 exactly 64 cycles after WAIT entry; a valid pulse injected 5 cycles later produces no second beat.
- Simultaneous events: valid on the final timeout cycle -> Error=0 and bank data returned. Req held high continuously for 3 transactions -> exactly 3 CmdAck pulses spaced by at least 4 cycles, and no double accept.
- With REGIF_RD_RESP_STATS_EN defined: 5 good reads and 2 errors -> rd_ok_cnt=5, rd_err_cnt=2. Preload near max -> counter saturates at 32'hFFFF_FFFF.
